// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - CPU-side DMA command issue and bus grant arbiter (optional watchdog: DMA_WATCHDOG_EN)
module dma_bus_arbiter #(
    parameter logic [15:0] DMA_ADDR  = 16'h01F4,
    parameter logic [15:0] DMA_LEN   = 16'd12,
    parameter int          WDT_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dev_int,
    input  logic        dma_done_int,
    input  logic        BR,
    input  logic        cpu_mem_busy,
    output logic        cmd,
    output logic [15:0] cmd_addr,
    output logic [15:0] cmd_len,
    output logic        BG,
    output logic        d_stall,
    output logic        irq_done,
    output logic        dma_err,
    output logic [15:0] grant_cycles,
    output logic [7:0]  lost_int
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BR   = 3'd2;
    localparam logic [2:0] S_DRAIN     = 3'd3;
    localparam logic [2:0] S_GRANT     = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_wdt_limit_range
        $error("dma_bus_arbiter: WDT_LIMIT out of range");
    end

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        pend;
    logic        done_seen;
    logic        done_any;
    logic        irq_next;
    logic        err_next;
    logic        irq_q;
    logic        err_q;
    logic [15:0] grant_q;
    logic [7:0]  lost_q;

`ifdef DMA_WATCHDOG_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_LIMIT - 1);

    logic [15:0] wdt_cnt;
    logic        wdt_watched;
    logic        wdt_hit;

    // Only the states that wait on the engine or the CPU port are supervised.
    assign wdt_watched = (state == S_WAIT_BR) || (state == S_DRAIN) || (state == S_WAIT_DONE);
    assign wdt_hit     = wdt_watched && (wdt_cnt == WDT_LAST);
`endif

    // Completion may already be latched or may arrive in the deciding cycle itself.
    assign done_any = done_seen | dma_done_int;

    // Next-state decode; completion is preferred over a fresh steal request in WAIT_DONE.
    always_comb begin
        state_next = state;
        irq_next   = 1'b0;
        err_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (dev_int || pend) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT_BR;
            end
            S_WAIT_BR: begin
                if (BR) begin
                    state_next = cpu_mem_busy ? S_DRAIN : S_GRANT;
                end
            end
            S_DRAIN: begin
                if (!cpu_mem_busy) begin
                    state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!BR) begin
                    if (done_any) begin
                        state_next = S_IDLE;
                        irq_next   = 1'b1;
                    end else begin
                        state_next = S_WAIT_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (done_any) begin
                    state_next = S_IDLE;
                    irq_next   = 1'b1;
                end else if (BR) begin
                    state_next = cpu_mem_busy ? S_DRAIN : S_GRANT;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
`ifdef DMA_WATCHDOG_EN
        // Abort only when the block would otherwise sit in the same state again.
        if (wdt_hit && (state_next == state)) begin
            state_next = S_IDLE;
            irq_next   = 1'b0;
            err_next   = 1'b1;
        end
`endif
    end

    // Main state register, completion latch and pulse outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            done_seen <= 1'b0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            irq_q <= irq_next;
            err_q <= err_next;
            if ((state == S_IDLE) || (state_next == S_IDLE)) begin
                done_seen <= 1'b0;
            end else if (dma_done_int) begin
                done_seen <= 1'b1;
            end
        end
    end

    // Pending start request and dropped-request counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend   <= 1'b0;
            lost_q <= 8'h00;
        end else if (err_next) begin
            pend <= 1'b0;
        end else if (state == S_IDLE) begin
            // Leaving IDLE consumes the request; a new dev_int arriving while
            // the pending one is being consumed is kept as the next request.
            pend <= pend & dev_int;
        end else if ((state != S_ISSUE) && dev_int) begin
            pend <= 1'b1;
            if (pend && (lost_q != 8'hFF)) begin
                lost_q <= lost_q + 8'd1;
            end
        end
    end

    // Saturating count of cycles during which the bus is lent.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_q <= 16'h0000;
        end else if ((state == S_GRANT) && (grant_q != 16'hFFFF)) begin
            grant_q <= grant_q + 16'd1;
        end
    end

`ifdef DMA_WATCHDOG_EN
    // Cycles spent in the current waiting state; restarts on every state change.
    always_ff @(posedge clk) begin
        if (!reset_n || (state_next != state)) begin
            wdt_cnt <= 16'h0000;
        end else if (wdt_watched && (wdt_cnt != 16'hFFFF)) begin
            wdt_cnt <= wdt_cnt + 16'd1;
        end
    end
`endif

    assign cmd          = (state == S_ISSUE);
    assign cmd_addr     = cmd ? DMA_ADDR : 16'h0000;
    assign cmd_len      = cmd ? DMA_LEN : 16'h0000;
    assign BG           = (state == S_GRANT);
    assign d_stall      = (state == S_DRAIN) || (state == S_GRANT);
    assign irq_done     = irq_q;
    assign dma_err      = err_q;
    assign grant_cycles = grant_q;
    assign lost_int     = lost_q;

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- CPU-side responder for the DMA bus handshake.
- Takes the external-device start interrupt and issues a one-cycle command with the transfer descriptor to the DMA engine.
- Answers the engine's bus request (BR) with a grant (BG) only after any in-flight CPU data-memory access has drained, and stalls new CPU data accesses while the bus is lent.
- Turns the DMA completion interrupt into a one-cycle notification to the CPU core.

Parameters:
- DMA_ADDR, 16'h01F4: target memory base address driven on cmd_addr.
- DMA_LEN, 12: transfer length in words, driven on cmd_len.
- WDT_LIMIT, 1024: watchdog cycle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- dev_int  in  1  start interrupt from the external device; level, sampled each cycle.
- dma_done_int  in  1  end-of-transfer interrupt from the DMA engine.
- BR  in  1  bus request from the DMA engine.
- cpu_mem_busy  in  1  CPU data port has a read/write in flight this cycle.
- cmd  out  1  one-cycle command strobe to the DMA engine.
- cmd_addr  out  16  DMA_ADDR while cmd=1, else 0.
- cmd_len  out  16  DMA_LEN while cmd=1, else 0.
- BG  out  1  bus grant to the DMA engine.
- d_stall  out  1  CPU must not start a new data access.
- irq_done  out  1  one-cycle completion pulse to the CPU.
- dma_err  out  1  one-cycle watchdog abort pulse.
- grant_cycles  out  16  saturating count of cycles with BG=1.
- lost_int  out  8  saturating count of dropped dev_int requests.

Behaviour:
- Reset: state=IDLE; cmd, BG, d_stall, irq_done, dma_err=0; cmd_addr, cmd_len=0; pend, done_seen=0; grant_cycles, lost_int=0.
- Reset mid-transfer drops BG in the same edge.
- States: IDLE, ISSUE, WAIT_BR, DRAIN, GRANT, WAIT_DONE.
- IDLE: dev_int=1 or pend=1 -> ISSUE; clear pend.
- ISSUE: cmd=1 with descriptor valid for exactly one cycle -> WAIT_BR.
- WAIT_BR:
  - BR=1 and cpu_mem_busy=0 -> GRANT.
  - BR=1 and cpu_mem_busy=1 -> DRAIN.
- DRAIN: d_stall=1; cpu_mem_busy=0 -> GRANT. No BG while cpu_mem_busy=1.
- GRANT: BG=1, d_stall=1.
  - BR=0 -> WAIT_DONE if done_seen=0, else IDLE with irq_done=1.
  - BG falls on the edge after BR is sampled low, so grant latency and release latency are each 1 cycle.
- WAIT_DONE: BG=0, d_stall=0.
  - BR=1 -> re-arbitrate (DRAIN/GRANT rules) for cycle-stealing bursts.
  - done_seen or dma_done_int=1 -> IDLE, irq_done=1 for one cycle.
- done_seen: set by dma_done_int in any non-IDLE state; cleared on entry to IDLE. Completion may therefore arrive before or after BR drops.
- dev_int outside IDLE/ISSUE: sets pend. If pend is already set, lost_int increments (saturating at 8'hFF).
- dev_int is level-sensitive. The device must deassert it after cmd; a level still high in IDLE re-triggers.
- BR=1 in IDLE or ISSUE: ignored, BG stays 0.
- dma_done_int in IDLE: ignored.
- grant_cycles: increments each cycle BG=1, saturates at 16'hFFFF.
- Simultaneous events:
  - BR falls and dma_done_int rises in the same GRANT cycle -> IDLE with irq_done.
  - dev_int in the same cycle as IDLE exit -> pend.

Optional Feature:
- DMA_WATCHDOG_EN defined:
  - A 16-bit counter clears on each state change and counts cycles spent in WAIT_BR, DRAIN or WAIT_DONE.
  - Reaching WDT_LIMIT -> IDLE, BG=0, dma_err=1 for one cycle, pend cleared, no irq_done.
- Undefined: no counter, states wait indefinitely, dma_err tied 0.

Test Plan:
- dev_int pulse at cycle 10; BR rises 2 cycles after cmd with cpu_mem_busy=0; BR held 4 cycles, then dma_done_int -> cmd high exactly 1 cycle with cmd_addr=16'h01F4, cmd_len=12; BG high 4 cycles starting 1 cycle after BR; irq_done 1 pulse; grant_cycles=4.
- BR rises while cpu_mem_busy=1 for 3 cycles -> d_stall=1 from the next cycle, BG stays 0 until cpu_mem_busy falls, then BG=1 one cycle later.
- Cycle stealing: BR high 1 cycle, low 2, repeated 12 times, then dma_done_int -> 12 separate BG pulses, a single irq_done, grant_cycles=12.
- dma_done_int arrives 1 cycle before BR drops -> irq_done fires the cycle after BG falls, not earlier.
- Three dev_int pulses during a GRANT -> pend set, lost_int=2; after irq_done, a second cmd is issued without a new dev_int.
- With DMA_WATCHDOG_EN and WDT_LIMIT=16: cmd issued, BR never asserted -> dma_err pulse 16 cycles after WAIT_BR entry, state IDLE, no irq_done. Without the macro, the block remains in WAIT_BR and dma_err stays 0.
